line_fill_ctrl: RTL and testbench
=================================

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, number of sets.
REQ-002 SHALL have parameter NUM_WAYS, default 4, associativity.
REQ-003 SHALL have parameter LINE_BYTES, default 16, line size; WORDS_PER_LINE = LINE_BYTES/4.
REQ-004 SHALL derive INDEX_BITS = clog2(NUM_SETS), WAY_BITS = max(1,clog2(NUM_WAYS)), WORD_SEL_BITS = max(1,clog2(WORDS_PER_LINE)).
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 fill_req  in  1  start line fill; sampled only in IDLE.
REQ-009 fill_index  in  INDEX_BITS  set to fill.
REQ-010 fill_way  in  WAY_BITS  way to fill.
REQ-011 fill_busy  out  1  high in FILL and DONE.
REQ-012 fill_done  out  1  one-cycle pulse when a fill completes.
REQ-013 mem_valid  in  1  refill beat valid.
REQ-014 mem_data  in  32  refill beat word, lowest word first.
REQ-015 mem_ready  out  1  beat accepted when mem_valid & mem_ready.
REQ-016 cpu_we  in  1  CPU store request to the array.
REQ-017 cpu_index / cpu_way / cpu_word  in  INDEX_BITS / WAY_BITS / WORD_SEL_BITS  CPU store address.
REQ-018 cpu_wdata  in  32  CPU store data.
REQ-019 cpu_stall  out  1  CPU store not performed this cycle; CPU holds the request.
REQ-020 arr_we / arr_index / arr_way / arr_word_sel / arr_wdata  out  1 / INDEX_BITS / WAY_BITS / WORD_SEL_BITS / 32  data-array write port.

Function
REQ-021 SHALL implement the FSM states IDLE, FILL and DONE.
REQ-022 IDLE with fill_req=1 SHALL latch fill_index/fill_way, clear the beat counter, and enter FILL next cycle.
REQ-023 FILL SHALL drive mem_ready=1; each accepted beat SHALL write mem_data to word = counter of the latched set/way in the same cycle, then increment the counter.
REQ-024 The beat accepted with counter = WORDS_PER_LINE-1 SHALL move the FSM to DONE; the counter SHALL not wrap within a fill.
REQ-025 DONE SHALL assert fill_done for exactly one cycle, ignore fill_req, and return to IDLE.
REQ-026 Port arbitration SHALL be combinational, and an accepted refill beat SHALL win the port: in that cycle cpu_stall = cpu_we.
REQ-027 In FILL with no beat, a CPU store to the latched index AND way SHALL stall; a store to any other set/way SHALL pass through.
REQ-028 In IDLE and DONE, CPU stores SHALL always pass: arr_* = cpu_*, arr_we = cpu_we, cpu_stall=0.
REQ-029 arr_we SHALL be 0 when neither source writes; arr_* address/data don't-care then.
REQ-030 Write latency SHALL be zero cycles: the array commits on the same clk edge the beat/store is granted.
REQ-031 fill_req held high across DONE SHALL start a new fill only from the following IDLE cycle.

Reset
REQ-032 rst SHALL force IDLE, counter 0, fill_busy=0, fill_done=0, mem_ready=0, and latched index/way 0.
REQ-033 rst asserted mid-fill SHALL abort the fill without fill_done; partially written words remain in the array, and no further beats are written.

Structure
REQ-034 WORDS_PER_LINE, the derived widths and the FSM state encoding SHALL reside in shared package cache_pkg.
REQ-035 SHALL contain no sub-modules; the parent instantiates data_array and connects the arr_* outputs to it.

Verification
REQ-036 Fill index 5, way 2, beats 0xA0..0xA3 back-to-back -> arr_we on 4 consecutive cycles at word 0..3; fill_done pulses one cycle after the last beat; fill_busy spans 5 cycles.
REQ-037 Gapped beats (mem_valid 1,0,1,0,1,1) -> only 4 writes occur, in word order; no fill_done before the 4th beat.
REQ-038 CPU store to set 5, way 2 during a FILL gap -> cpu_stall=1 and no write; store to set 6 -> passes with cpu_stall=0.
REQ-039 CPU store coincident with a beat -> beat written, cpu_stall=1; the store is written on the next beat-free cycle.
REQ-040 rst after 2 beats -> IDLE immediately, fill_busy=0, no fill_done; a new fill restarts at word 0.
REQ-041 fill_req held high continuously -> second fill begins in the IDLE cycle after DONE, never in DONE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-controller constants: default geometry, derived widths and line-fill FSM encoding.
package cache_pkg;

    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_SETS_DEF   = 64;
    localparam int NUM_WAYS_DEF   = 4;
    localparam int LINE_BYTES_DEF = 16;

    localparam int WORDS_PER_LINE = LINE_BYTES_DEF / 4;
    localparam int INDEX_BITS     = $clog2(NUM_SETS_DEF);
    localparam int WAY_BITS       = min1_clog2(NUM_WAYS_DEF);
    localparam int WORD_SEL_BITS  = min1_clog2(WORDS_PER_LINE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/line_fill_if.sv
// Line-fill controller bus: fill handshake, refill beats, CPU store port and data-array write port.
interface line_fill_if
    import cache_pkg::*;
#(
    parameter int IDX_W = INDEX_BITS,
    parameter int WAY_W = WAY_BITS,
    parameter int SEL_W = WORD_SEL_BITS
);
    logic             fill_req;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;
    logic             fill_busy;
    logic             fill_done;

    logic             mem_valid;
    logic [31:0]      mem_data;
    logic             mem_ready;

    logic             cpu_we;
    logic [IDX_W-1:0] cpu_index;
    logic [WAY_W-1:0] cpu_way;
    logic [SEL_W-1:0] cpu_word;
    logic [31:0]      cpu_wdata;
    logic             cpu_stall;

    logic             arr_we;
    logic [IDX_W-1:0] arr_index;
    logic [WAY_W-1:0] arr_way;
    logic [SEL_W-1:0] arr_word_sel;
    logic [31:0]      arr_wdata;

    modport slave (
        input  fill_req, fill_index, fill_way, mem_valid, mem_data,
               cpu_we, cpu_index, cpu_way, cpu_word, cpu_wdata,
        output fill_busy, fill_done, mem_ready, cpu_stall,
               arr_we, arr_index, arr_way, arr_word_sel, arr_wdata
    );

    modport master (
        output fill_req, fill_index, fill_way, mem_valid, mem_data,
               cpu_we, cpu_index, cpu_way, cpu_word, cpu_wdata,
        input  fill_busy, fill_done, mem_ready, cpu_stall,
               arr_we, arr_index, arr_way, arr_word_sel, arr_wdata
    );
endinterface

// File: rtl/line_fill_ctrl.sv
// Cache line-fill controller: streams refill beats into one set/way and arbitrates the
// data-array write port against CPU stores.
//   state | meaning
//   IDLE  | waiting for fill_req; CPU stores pass straight through
//   FILL  | accepting refill beats; stores to the line being filled are stalled
//   DONE  | one-cycle completion pulse; fill_req ignored
module line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    line_fill_if.slave  bus
);
    localparam int WPL   = LINE_BYTES / 4;
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = min1_clog2(NUM_WAYS);
    localparam int SEL_W = min1_clog2(WPL);

    logic [1:0]       state;
    logic [SEL_W-1:0] beat_cnt;
    logic [IDX_W-1:0] lat_index;
    logic [WAY_W-1:0] lat_way;
    logic             beat;
    logic             line_hit;
    logic             last_beat;

    assign beat      = (state == ST_FILL) && bus.mem_valid;
    assign line_hit  = (state == ST_FILL) && (bus.cpu_index == lat_index) && (bus.cpu_way == lat_way);
    assign last_beat = (beat_cnt == SEL_W'(WPL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            lat_index <= '0;
            lat_way   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.fill_req) begin
                        lat_index <= bus.fill_index;
                        lat_way   <= bus.fill_way;
                        beat_cnt  <= '0;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // The counter parks on the last word rather than wrapping.
                    if (beat) begin
                        if (last_beat) state <= ST_DONE;
                        else           beat_cnt <= beat_cnt + SEL_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_ready = (state == ST_FILL);
    assign bus.fill_busy = (state == ST_FILL) || (state == ST_DONE);
    assign bus.fill_done = (state == ST_DONE);

    // An accepted beat always owns the array port; the CPU only waits on the line in flight.
    always_comb begin
        bus.arr_we       = bus.cpu_we;
        bus.arr_index    = bus.cpu_index;
        bus.arr_way      = bus.cpu_way;
        bus.arr_word_sel = bus.cpu_word;
        bus.arr_wdata    = bus.cpu_wdata;
        bus.cpu_stall    = 1'b0;
        if (beat) begin
            bus.arr_we       = 1'b1;
            bus.arr_index    = lat_index;
            bus.arr_way      = lat_way;
            bus.arr_word_sel = beat_cnt;
            bus.arr_wdata    = bus.mem_data;
            bus.cpu_stall    = bus.cpu_we;
        end else if (line_hit && bus.cpu_we) begin
            bus.arr_we    = 1'b0;
            bus.cpu_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Bench for line_fill_ctrl: directed scenarios plus randomized traffic against a fill-progress model.
module tb_line_fill_ctrl;
    import cache_pkg::*;

    localparam int NSETS  = 64;
    localparam int NWAYS  = 4;
    localparam int LBYTES = 16;
    localparam int WPL    = LBYTES / 4;
    localparam int DEPTH  = NSETS * NWAYS * WPL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_fill_if bus ();

    line_fill_ctrl #(.NUM_SETS(NSETS), .NUM_WAYS(NWAYS), .LINE_BYTES(LBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: is a line being filled, is the completion pulse due, which line, how many beats so far.
    bit m_filling, m_done;
    int m_idx, m_way, m_beats;

    bit exp_busy, exp_done, exp_ready, exp_stall, exp_we;
    int exp_idx, exp_way, exp_word;
    logic [31:0] exp_data;

    logic [31:0] exp_arr [DEPTH];
    bit          exp_written [DEPTH];
    logic [31:0] dut_arr [DEPTH];
    bit          dut_written [DEPTH];

    function automatic int aidx(input int s, input int w, input int d);
        return (s * NWAYS + w) * WPL + d;
    endfunction

    // Stand-in for the parent's data array, fed from the write port.
    always @(posedge clk) begin
        if (bus.arr_we === 1'b1) begin
            dut_arr[aidx(int'(bus.arr_index), int'(bus.arr_way), int'(bus.arr_word_sel))] <= bus.arr_wdata;
            dut_written[aidx(int'(bus.arr_index), int'(bus.arr_way), int'(bus.arr_word_sel))] <= 1'b1;
        end
    end

    task automatic model_reset();
        m_filling = 0; m_done = 0; m_idx = 0; m_way = 0; m_beats = 0;
    endtask

    task automatic model_comb();
        bit beat, hit;
        beat = m_filling && bus.mem_valid;
        hit  = m_filling && (int'(bus.cpu_index) == m_idx) && (int'(bus.cpu_way) == m_way);
        exp_busy  = m_filling || m_done;
        exp_done  = m_done;
        exp_ready = m_filling;
        if (beat) begin
            exp_we = 1; exp_idx = m_idx; exp_way = m_way; exp_word = m_beats;
            exp_data = bus.mem_data; exp_stall = bus.cpu_we;
        end else if (bus.cpu_we && hit) begin
            exp_we = 0; exp_stall = 1;
        end else begin
            exp_we = bus.cpu_we; exp_stall = 0;
            exp_idx = int'(bus.cpu_index); exp_way = int'(bus.cpu_way);
            exp_word = int'(bus.cpu_word); exp_data = bus.cpu_wdata;
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        model_comb();
        if (exp_we) begin
            exp_arr[aidx(exp_idx, exp_way, exp_word)]     = exp_data;
            exp_written[aidx(exp_idx, exp_way, exp_word)] = 1;
        end
        if (!rst) begin
            if (m_done) m_done = 0;
            else if (m_filling) begin
                if (bus.mem_valid) begin
                    m_beats++;
                    if (m_beats == WPL) begin m_filling = 0; m_done = 1; end
                end
            end else if (bus.fill_req) begin
                m_filling = 1; m_idx = int'(bus.fill_index); m_way = int'(bus.fill_way); m_beats = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.fill_req = 0; bus.fill_index = '0; bus.fill_way = '0;
        bus.mem_valid = 0; bus.mem_data = '0;
        bus.cpu_we = 0; bus.cpu_index = '0; bus.cpu_way = '0; bus.cpu_word = '0; bus.cpu_wdata = '0;
    endtask

    task automatic start_fill(input int s, input int w);
        bus.fill_req = 1; bus.fill_index = 6'(s); bus.fill_way = 2'(w);
        settle(); tick();
        bus.fill_req = 0;
    endtask

    task automatic test_reset();
        rst = 1; model_reset();
        repeat (2) @(negedge clk);
        settle();
        n_total++;
        if ({bus.fill_busy, bus.fill_done, bus.mem_ready, bus.cpu_stall, bus.arr_we} !== 5'b0)
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus.fill_busy, bus.fill_done, bus.mem_ready, bus.cpu_stall, bus.arr_we});
        else n_pass++;
        rst = 0;
        tick();
        bus.cpu_we = 1; bus.cpu_index = 6'd9; bus.cpu_way = 2'd1; bus.cpu_word = 2'd3; bus.cpu_wdata = 32'h1234_5678;
        settle();
        n_total++;
        if ({bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata} !==
            {1'b0, 1'b1, 6'd9, 2'd1, 2'd3, 32'h1234_5678})
            $display("FAIL idle_store_pass got stall=%b we=%b idx=%0d data=%h exp stall=0 we=1 idx=9 data=12345678",
                     bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_wdata);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_fill_basic();
        int busy_cycles = 0;
        bus.fill_req = 1; bus.fill_index = 6'd5; bus.fill_way = 2'd2;
        settle();
        if (bus.fill_busy === 1'b1) busy_cycles++;
        tick();
        bus.fill_req = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1; bus.mem_data = 32'hA0 + 32'(i);
            settle();
            if (bus.fill_busy === 1'b1) busy_cycles++;
            n_total++;
            if ({bus.arr_we, bus.fill_done, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata} !==
                {1'b1, 1'b0, 6'd5, 2'd2, 2'(i), 32'hA0 + 32'(i)})
                $display("FAIL basic_beat%0d got we=%b done=%b idx=%0d way=%0d word=%0d data=%h exp we=1 done=0 idx=5 way=2 word=%0d data=%h",
                         i, bus.arr_we, bus.fill_done, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata,
                         i, 32'hA0 + 32'(i));
            else n_pass++;
            tick();
        end
        bus.mem_valid = 0;
        settle();
        if (bus.fill_busy === 1'b1) busy_cycles++;
        n_total++;
        if ({bus.fill_done, bus.fill_busy, bus.mem_ready} !== 3'b110)
            $display("FAIL basic_done_pulse got done/busy/ready=%b exp=110", {bus.fill_done, bus.fill_busy, bus.mem_ready});
        else n_pass++;
        tick();
        settle();
        if (bus.fill_busy === 1'b1) busy_cycles++;
        n_total++;
        if ({bus.fill_done, bus.fill_busy} !== 2'b00)
            $display("FAIL basic_back_idle got done/busy=%b exp=00", {bus.fill_done, bus.fill_busy});
        else n_pass++;
        n_total++;
        if (busy_cycles !== 5) $display("FAIL basic_busy_span got=%0d exp=5", busy_cycles);
        else n_pass++;
        tick();
    endtask

    task automatic test_gapped();
        bit pat [6] = '{1, 0, 1, 0, 1, 1};
        int s, w, nb;
        s = $urandom_range(0, NSETS - 1); w = $urandom_range(0, NWAYS - 1); nb = 0;
        start_fill(s, w);
        for (int k = 0; k < 6; k++) begin
            bus.mem_valid = pat[k]; bus.mem_data = $urandom;
            settle();
            n_total++;
            if ({bus.arr_we, bus.fill_done} !== {pat[k], 1'b0})
                $display("FAIL gapped_cycle%0d got we/done=%b exp=%b0", k, {bus.arr_we, bus.fill_done}, pat[k]);
            else n_pass++;
            if (pat[k]) begin
                n_total++;
                if ({bus.arr_index, bus.arr_word_sel} !== {6'(s), 2'(nb)})
                    $display("FAIL gapped_order%0d got idx=%0d word=%0d exp idx=%0d word=%0d",
                             k, bus.arr_index, bus.arr_word_sel, s, nb);
                else n_pass++;
                nb++;
            end
            tick();
        end
        bus.mem_valid = 0;
        settle();
        n_total++;
        if ({bus.fill_done, bus.arr_we} !== 2'b10)
            $display("FAIL gapped_done got done/we=%b exp=10", {bus.fill_done, bus.arr_we});
        else n_pass++;
        tick();
    endtask

    task automatic test_cpu_stall();
        logic [31:0] d_cpu, d_beat;
        start_fill(5, 2);
        bus.cpu_we = 1; bus.cpu_index = 6'd5; bus.cpu_way = 2'd2; bus.cpu_word = 2'd1; bus.cpu_wdata = $urandom;
        settle();
        n_total++;
        if ({bus.cpu_stall, bus.arr_we} !== 2'b10)
            $display("FAIL stall_same_line got stall/we=%b exp=10", {bus.cpu_stall, bus.arr_we});
        else n_pass++;
        tick();
        d_cpu = $urandom;
        bus.cpu_index = 6'd6; bus.cpu_wdata = d_cpu;
        settle();
        n_total++;
        if ({bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_wdata} !== {1'b0, 1'b1, 6'd6, d_cpu})
            $display("FAIL stall_other_set got stall=%b we=%b idx=%0d data=%h exp stall=0 we=1 idx=6 data=%h",
                     bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_wdata, d_cpu);
        else n_pass++;
        tick();
        d_cpu = $urandom; d_beat = $urandom;
        bus.cpu_index = 6'd7; bus.cpu_way = 2'd0; bus.cpu_word = 2'd3; bus.cpu_wdata = d_cpu;
        bus.mem_valid = 1; bus.mem_data = d_beat;
        settle();
        n_total++;
        if ({bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata} !==
            {1'b1, 1'b1, 6'd5, 2'd2, 2'd0, d_beat})
            $display("FAIL stall_beat_wins got stall=%b we=%b idx=%0d way=%0d word=%0d data=%h exp stall=1 we=1 idx=5 way=2 word=0 data=%h",
                     bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata, d_beat);
        else n_pass++;
        tick();
        bus.mem_valid = 0;
        settle();
        n_total++;
        if ({bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata} !==
            {1'b0, 1'b1, 6'd7, 2'd0, 2'd3, d_cpu})
            $display("FAIL stall_retry got stall=%b we=%b idx=%0d way=%0d word=%0d data=%h exp stall=0 we=1 idx=7 way=0 word=3 data=%h",
                     bus.cpu_stall, bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata, d_cpu);
        else n_pass++;
        tick();
        bus.cpu_we = 0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1; bus.mem_data = $urandom;
            settle(); tick();
        end
        bus.mem_valid = 0;
        bus.cpu_we = 1; bus.cpu_index = 6'd5; bus.cpu_way = 2'd2; bus.cpu_word = 2'd2; bus.cpu_wdata = $urandom;
        settle();
        n_total++;
        if ({bus.fill_done, bus.cpu_stall, bus.arr_we, bus.arr_index} !== {1'b1, 1'b0, 1'b1, 6'd5})
            $display("FAIL stall_done_pass got done=%b stall=%b we=%b idx=%0d exp done=1 stall=0 we=1 idx=5",
                     bus.fill_done, bus.cpu_stall, bus.arr_we, bus.arr_index);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int s2;
        start_fill($urandom_range(0, NSETS - 1), $urandom_range(0, NWAYS - 1));
        for (int i = 0; i < 2; i++) begin
            bus.mem_valid = 1; bus.mem_data = $urandom;
            settle(); tick();
        end
        rst = 1; model_reset();
        settle();
        n_total++;
        if ({bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we} !== 4'b0)
            $display("FAIL rstmid_abort got busy/done/ready/we=%b exp=0000",
                     {bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we});
        else n_pass++;
        tick();
        rst = 0;
        settle();
        n_total++;
        if ({bus.fill_busy, bus.fill_done, bus.arr_we} !== 3'b0)
            $display("FAIL rstmid_after got busy/done/we=%b exp=000", {bus.fill_busy, bus.fill_done, bus.arr_we});
        else n_pass++;
        tick();
        bus.mem_valid = 0;
        s2 = $urandom_range(0, NSETS - 1);
        start_fill(s2, 1);
        bus.mem_valid = 1; bus.mem_data = $urandom;
        settle();
        n_total++;
        if ({bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel} !== {1'b1, 6'(s2), 2'd1, 2'd0})
            $display("FAIL rstmid_restart got we=%b idx=%0d way=%0d word=%0d exp we=1 idx=%0d way=1 word=0",
                     bus.arr_we, bus.arr_index, bus.arr_way, bus.arr_word_sel, s2);
        else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_data = $urandom;
            settle(); tick();
        end
        bus.mem_valid = 0;
        settle(); tick();
    endtask

    task automatic test_back_to_back();
        bus.fill_req = 1; bus.fill_index = 6'd10; bus.fill_way = 2'd1;
        bus.mem_valid = 1; bus.mem_data = $urandom;
        settle();
        n_total++;
        if ({bus.fill_busy, bus.mem_ready, bus.arr_we} !== 3'b000)
            $display("FAIL b2b_idle0 got busy/ready/we=%b exp=000", {bus.fill_busy, bus.mem_ready, bus.arr_we});
        else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_data = $urandom;
            settle();
            n_total++;
            if ({bus.mem_ready, bus.arr_we, bus.arr_word_sel} !== {1'b1, 1'b1, 2'(k)})
                $display("FAIL b2b_beat%0d got ready=%b we=%b word=%0d exp ready=1 we=1 word=%0d",
                         k, bus.mem_ready, bus.arr_we, bus.arr_word_sel, k);
            else n_pass++;
            tick();
        end
        settle();
        n_total++;
        if ({bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we} !== 4'b1100)
            $display("FAIL b2b_done got busy/done/ready/we=%b exp=1100",
                     {bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we});
        else n_pass++;
        tick();
        bus.fill_index = 6'd11;
        settle();
        n_total++;
        if ({bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we} !== 4'b0000)
            $display("FAIL b2b_idle_gap got busy/done/ready/we=%b exp=0000",
                     {bus.fill_busy, bus.fill_done, bus.mem_ready, bus.arr_we});
        else n_pass++;
        tick();
        bus.fill_req = 0;
        settle();
        n_total++;
        if ({bus.mem_ready, bus.arr_we, bus.arr_index, bus.arr_word_sel} !== {1'b1, 1'b1, 6'd11, 2'd0})
            $display("FAIL b2b_second_fill got ready=%b we=%b idx=%0d word=%0d exp ready=1 we=1 idx=11 word=0",
                     bus.mem_ready, bus.arr_we, bus.arr_index, bus.arr_word_sel);
        else n_pass++;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.mem_data = $urandom;
            settle(); tick();
        end
        bus.mem_valid = 0;
        settle(); tick();
        settle(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (rst) model_reset();
            bus.fill_req   = ($urandom_range(0, 3) == 0);
            bus.fill_index = 6'($urandom_range(0, 3));
            bus.fill_way   = 2'($urandom_range(0, 3));
            bus.mem_valid  = $urandom_range(0, 1);
            bus.mem_data   = $urandom;
            bus.cpu_we     = $urandom_range(0, 1);
            bus.cpu_index  = 6'($urandom_range(0, 3));
            bus.cpu_way    = 2'($urandom_range(0, 3));
            bus.cpu_word   = 2'($urandom_range(0, 3));
            bus.cpu_wdata  = $urandom;
            settle();
            n_total++;
            if ({bus.fill_busy, bus.fill_done, bus.mem_ready, bus.cpu_stall, bus.arr_we} !==
                {exp_busy, exp_done, exp_ready, exp_stall, exp_we})
                $display("FAIL rand_ctrl cycle %0d got busy/done/ready/stall/we=%b exp=%b", c,
                         {bus.fill_busy, bus.fill_done, bus.mem_ready, bus.cpu_stall, bus.arr_we},
                         {exp_busy, exp_done, exp_ready, exp_stall, exp_we});
            else n_pass++;
            if (exp_we) begin
                n_total++;
                if ({bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata} !==
                    {6'(exp_idx), 2'(exp_way), 2'(exp_word), exp_data})
                    $display("FAIL rand_write cycle %0d got idx=%0d way=%0d word=%0d data=%h exp idx=%0d way=%0d word=%0d data=%h",
                             c, bus.arr_index, bus.arr_way, bus.arr_word_sel, bus.arr_wdata,
                             exp_idx, exp_way, exp_word, exp_data);
                else n_pass++;
            end
            tick();
        end
        rst = 0;
        idle_inputs();
        repeat (8) begin settle(); tick(); end
    endtask

    task automatic test_array();
        int mism = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if ((dut_written[a] != exp_written[a]) || (exp_written[a] && (dut_arr[a] !== exp_arr[a]))) begin
                mism++;
                if (first < 0) first = a;
            end
        end
        n_total++;
        if (mism != 0)
            $display("FAIL array_contents got %0d differing words (first at %0d) exp 0", mism, first);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill_basic();
        test_gapped();
        test_cpu_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_array();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
